// File: rtl/timer_reg_bank_pkg.sv
// timer_reg_bank_pkg
//   Shared definitions for the timer register bank: the register map, the
//   channel window layout, the divisor limit, reset constants and the decode
//   types used by timer_reg_bank and timer_cmp_ch.
package timer_reg_bank_pkg;

   // Global register offsets (byte addresses)
   localparam logic [11:0] OFF_TCR  = 12'h000;
   localparam logic [11:0] OFF_TDR0 = 12'h004;
   localparam logic [11:0] OFF_TDR1 = 12'h008;
   localparam logic [11:0] OFF_TIER = 12'h014;
   localparam logic [11:0] OFF_TISR = 12'h018;

   // Channel c occupies CH_BASE + c * 2**CH_STRIDE_LG2 (stride 0x10)
   localparam logic [11:0] CH_BASE       = 12'h020;
   localparam int unsigned CH_STRIDE_LG2 = 4;

   // Divisor select: legal range 0..DIV_MAX
   localparam logic [3:0] DIV_MAX = 4'd8;

   // Reset constants
   localparam logic [3:0] DIV_RST   = 4'd1;
   localparam logic       TIER_RST  = 1'b0;
   localparam logic [1:0] CCTRL_RST = 2'b00;

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_TCR  = 3'd1,
      SEL_TDR0 = 3'd2,
      SEL_TDR1 = 3'd3,
      SEL_TIER = 3'd4,
      SEL_TISR = 3'd5,
      SEL_CH   = 3'd6
   } reg_sel_e;

   // Word inside one channel window
   typedef enum logic [1:0] {
      SUB_CMP_LO = 2'd0,
      SUB_CMP_HI = 2'd1,
      SUB_CCTRL  = 2'd2,
      SUB_CSTAT  = 2'd3
   } ch_sub_e;

   function automatic logic div_val_legal(input logic [3:0] v);
      return (v <= DIV_MAX);
   endfunction

endpackage

// File: rtl/timer_cmp_ch.sv
// timer_cmp_ch
//   One compare channel: holds CMP (CNT_W bits, written as two 32-bit halves),
//   CCTRL {auto_clr, int_en} and the CSTAT match flag.
//   Ports: clk/rst (sync active-high), count (live counter), wr_en/sub/wdata
//   (write into this channel's window), match (count == CMP, combinational),
//   cstat (match flag), int_pend (flag & int_en), clr_req (match edge with
//   auto_clr set), rword (read data of the word selected by sub).
module timer_cmp_ch
   import timer_reg_bank_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count,
   input  logic             wr_en,
   input  ch_sub_e          sub,
   input  logic [31:0]      wdata,
   output logic             match,
   output logic             cstat,
   output logic             int_pend,
   output logic             clr_req,
   output logic [31:0]      rword
);

   logic [CNT_W-1:0] cmp_q, cmp_d;
   logic [1:0]       cctrl_q, cctrl_d;
   logic             cstat_q, cstat_d;
   logic             match_dly_q, match_dly_d;
   logic             match_event;

   // Compare, rising-edge detect and next-state of the channel registers
   always_comb begin
      cmp_d       = cmp_q;
      cctrl_d     = cctrl_q;
      cstat_d     = cstat_q;
      match       = (count == cmp_q);
      match_dly_d = match;
      match_event = match & ~match_dly_q;

      if (wr_en && (sub == SUB_CMP_LO)) begin
         cmp_d[31:0] = wdata;
      end else if (wr_en && (sub == SUB_CMP_HI)) begin
         cmp_d[CNT_W-1:32] = wdata[CNT_W-33:0];
      end else begin
         cmp_d = cmp_q;
      end

      if (wr_en && (sub == SUB_CCTRL)) begin
         cctrl_d = wdata[1:0];
      end else begin
         cctrl_d = cctrl_q;
      end

      // A new match edge wins over a W1C landing in the same cycle
      if (match_event) begin
         cstat_d = 1'b1;
      end else if (wr_en && (sub == SUB_CSTAT) && wdata[0]) begin
         cstat_d = 1'b0;
      end else begin
         cstat_d = cstat_q;
      end
   end

   // Read word for the selected offset inside the channel window
   always_comb begin
      rword = 32'd0;
      case (sub)
         SUB_CMP_LO: rword = cmp_q[31:0];
         SUB_CMP_HI: rword = 32'(cmp_q[CNT_W-1:32]);
         SUB_CCTRL:  rword = {30'd0, cctrl_q};
         SUB_CSTAT:  rword = {31'd0, cstat_q};
         default:    rword = 32'd0;
      endcase
   end

   // Channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_q       <= {CNT_W{1'b1}};
         cctrl_q     <= CCTRL_RST;
         cstat_q     <= 1'b0;
         match_dly_q <= 1'b0;
      end else begin
         cmp_q       <= cmp_d;
         cctrl_q     <= cctrl_d;
         cstat_q     <= cstat_d;
         match_dly_q <= match_dly_d;
      end
   end

   assign cstat    = cstat_q;
   assign int_pend = cstat_q & cctrl_q[0];
   assign clr_req  = match_event & cctrl_q[1];

endmodule

// File: rtl/timer_reg_bank.sv
// timer_reg_bank
//   Register bank for a free-running timer with NUM_CH compare channels.
//   Ports: sys_clk/sys_rst (sync active-high); w_en/r_en/addr/wdata (register
//   access); count (live counter from the timer core); rdata/rvalid (read data
//   one cycle after r_en); err (unmapped-access pulse); timer_en/div_en/
//   count_clr/div_val (timer control); cnt_ld_lo/cnt_ld_hi/cnt_ld_data (counter
//   load pulses); match (per-channel compare); irq (combined interrupt).
module timer_reg_bank
   import timer_reg_bank_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 64
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              w_en,
   input  logic              r_en,
   input  logic [11:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [CNT_W-1:0]  count,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              err,
   output logic              timer_en,
   output logic              div_en,
   output logic              count_clr,
   output logic [3:0]        div_val,
   output logic              cnt_ld_lo,
   output logic              cnt_ld_hi,
   output logic [31:0]       cnt_ld_data,
   output logic [NUM_CH-1:0] match,
   output logic              irq
);

   // Only channel 0 may restart the counter on a match
   localparam logic [NUM_CH-1:0] AUTO_CLR_MASK = NUM_CH'(1);

   reg_sel_e    sel;
   ch_sub_e     sub;
   logic [1:0]  ch_idx;
   logic [11:0] ch_off, ch_num;
   logic [31:0] rd_word, ch_rd;

   logic [NUM_CH-1:0] ch_sel, ch_wr, ch_cstat, ch_pend, ch_clr_req;
   logic [31:0]       ch_rword [NUM_CH];

   logic        timer_en_q, timer_en_d, div_en_q, div_en_d, tcr_clr_q, tcr_clr_d;
   logic [3:0]  div_val_q, div_val_d;
   logic        tier_q, tier_d, irq_q, irq_d, auto_clr_q, auto_clr_d;
   logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d, ld_data_q, ld_data_d;
   logic        rvalid_q, rvalid_d, err_q, err_d, ld_lo_q, ld_lo_d, ld_hi_q, ld_hi_d;

   assign ch_off = addr - CH_BASE;
   assign ch_num = ch_off >> CH_STRIDE_LG2;
   assign sub    = ch_sub_e'(ch_off[3:2]);

   // Address decode; unaligned or out-of-range channel addresses are unmapped
   always_comb begin
      sel    = SEL_NONE;
      ch_idx = 2'd0;
      if (addr[1:0] != 2'b00) begin
         sel = SEL_NONE;
      end else if ((addr >= CH_BASE) && (ch_num < 12'(NUM_CH))) begin
         sel    = SEL_CH;
         ch_idx = ch_num[1:0];
      end else begin
         case (addr)
            OFF_TCR:  sel = SEL_TCR;
            OFF_TDR0: sel = SEL_TDR0;
            OFF_TDR1: sel = SEL_TDR1;
            OFF_TIER: sel = SEL_TIER;
            OFF_TISR: sel = SEL_TISR;
            default:  sel = SEL_NONE;
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_sel[c] = (sel == SEL_CH) && (ch_idx == 2'(c));
      assign ch_wr[c]  = w_en & ch_sel[c];

      timer_cmp_ch #(.CNT_W(CNT_W)) u_ch (
         .clk      (sys_clk),
         .rst      (sys_rst),
         .count    (count),
         .wr_en    (ch_wr[c]),
         .sub      (sub),
         .wdata    (wdata),
         .match    (match[c]),
         .cstat    (ch_cstat[c]),
         .int_pend (ch_pend[c]),
         .clr_req  (ch_clr_req[c]),
         .rword    (ch_rword[c])
      );
   end

   // Read multiplexer over pre-write register state
   always_comb begin
      ch_rd = 32'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_rd = ch_rd | (ch_sel[c] ? ch_rword[c] : 32'd0);
      end
      rd_word = 32'd0;
      case (sel)
         SEL_TCR:  rd_word = {20'd0, div_val_q, 5'd0, tcr_clr_q, div_en_q, timer_en_q};
         SEL_TDR0: rd_word = count[31:0];
         SEL_TDR1: rd_word = shadow_q;
         SEL_TIER: rd_word = {31'd0, tier_q};
         SEL_TISR: rd_word = 32'(ch_cstat);
         SEL_CH:   rd_word = ch_rd;
         default:  rd_word = 32'd0;
      endcase
   end

   // Next-state for control, load pulses, read port, error and interrupt
   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      tcr_clr_d  = tcr_clr_q;
      div_val_d  = div_val_q;
      if (w_en && (sel == SEL_TCR)) begin
         timer_en_d = wdata[0];
         div_en_d   = wdata[1];
         tcr_clr_d  = wdata[2];
         if (div_val_legal(wdata[11:8])) begin
            div_val_d = wdata[11:8];
         end else begin
            div_val_d = div_val_q;
         end
      end else begin
         div_val_d = div_val_q;
      end

      if (w_en && (sel == SEL_TIER)) begin
         tier_d = wdata[0];
      end else begin
         tier_d = tier_q;
      end

      ld_lo_d = w_en && (sel == SEL_TDR0);
      ld_hi_d = w_en && (sel == SEL_TDR1);
      if (ld_lo_d || ld_hi_d) begin
         ld_data_d = wdata;
      end else begin
         ld_data_d = ld_data_q;
      end

      if (r_en) begin
         rdata_d  = rd_word;
         rvalid_d = 1'b1;
      end else begin
         rdata_d  = rdata_q;
         rvalid_d = 1'b0;
      end

      // Upper counter half is frozen by a TDR0 read for a coherent TDR1 read
      if (r_en && (sel == SEL_TDR0)) begin
         shadow_d = 32'(count[CNT_W-1:32]);
      end else begin
         shadow_d = shadow_q;
      end

      err_d      = (w_en | r_en) & (sel == SEL_NONE);
      irq_d      = tier_q & (|ch_pend);
      auto_clr_d = |(ch_clr_req & AUTO_CLR_MASK);
   end

   // Bank registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         timer_en_q <= 1'b0;
         div_en_q   <= 1'b0;
         tcr_clr_q  <= 1'b0;
         div_val_q  <= DIV_RST;
         tier_q     <= TIER_RST;
         shadow_q   <= 32'd0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         irq_q      <= 1'b0;
         ld_lo_q    <= 1'b0;
         ld_hi_q    <= 1'b0;
         ld_data_q  <= 32'd0;
         auto_clr_q <= 1'b0;
      end else begin
         timer_en_q <= timer_en_d;
         div_en_q   <= div_en_d;
         tcr_clr_q  <= tcr_clr_d;
         div_val_q  <= div_val_d;
         tier_q     <= tier_d;
         shadow_q   <= shadow_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
         ld_lo_q    <= ld_lo_d;
         ld_hi_q    <= ld_hi_d;
         ld_data_q  <= ld_data_d;
         auto_clr_q <= auto_clr_d;
      end
   end

   assign timer_en    = timer_en_q;
   assign div_en      = div_en_q;
   assign count_clr   = tcr_clr_q | auto_clr_q;
   assign div_val     = div_val_q;
   assign cnt_ld_lo   = ld_lo_q;
   assign cnt_ld_hi   = ld_hi_q;
   assign cnt_ld_data = ld_data_q;
   assign rdata       = rdata_q;
   assign rvalid      = rvalid_q;
   assign err         = err_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_timer_reg_bank.sv
// tb_timer_reg_bank
//   Randomized and directed stimulus for timer_reg_bank, checked every cycle
//   against a behavioural model of the register bank kept in this module.
module tb_timer_reg_bank;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 64;
   localparam logic [63:0] MASK = {64{1'b1}} >> (64 - CNT_W);

   logic              sys_clk = 1'b0;
   logic              sys_rst, w_en, r_en;
   logic [11:0]       addr;
   logic [31:0]       wdata;
   logic [CNT_W-1:0]  count;
   logic [31:0]       rdata, cnt_ld_data;
   logic              rvalid, err, timer_en, div_en, count_clr, cnt_ld_lo, cnt_ld_hi, irq;
   logic [3:0]        div_val;
   logic [NUM_CH-1:0] match;

   timer_reg_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .w_en(w_en), .r_en(r_en),
      .addr(addr), .wdata(wdata), .count(count), .rdata(rdata), .rvalid(rvalid),
      .err(err), .timer_en(timer_en), .div_en(div_en), .count_clr(count_clr),
      .div_val(div_val), .cnt_ld_lo(cnt_ld_lo), .cnt_ld_hi(cnt_ld_hi),
      .cnt_ld_data(cnt_ld_data), .match(match), .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic        m_ten, m_den, m_clr, m_tier, m_irq, m_rvalid, m_err, m_ldlo, m_ldhi, m_aclr;
   logic [3:0]  m_div;
   logic [31:0] m_rdata, m_lddata, m_shadow;
   logic [63:0] m_cmp   [NUM_CH];
   logic [1:0]  m_cctrl [NUM_CH];
   logic        m_cstat [NUM_CH];
   logic        m_prev  [NUM_CH];
   logic [63:0] cur_cnt;

   logic [11:0] addr_tab [18] = '{12'h000, 12'h004, 12'h008, 12'h014, 12'h018,
                                   12'h020, 12'h024, 12'h028, 12'h02C, 12'h030,
                                   12'h034, 12'h038, 12'h03C, 12'h040, 12'h050,
                                   12'h00C, 12'h002, 12'h03C};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Kind: 0 unmapped, 1 TCR, 2 TDR0, 3 TDR1, 4 TIER, 5 TISR, 6 channel
   function automatic int m_kind(input logic [11:0] a, output int ch, output int sub);
      int ai;
      ai  = int'(a);
      ch  = 0;
      sub = 0;
      if (ai % 4 != 0) return 0;
      if (ai >= 32 && ai < 32 + 16 * NUM_CH) begin
         ch  = (ai - 32) / 16;
         sub = (ai % 16) / 4;
         return 6;
      end
      case (ai)
         0:       return 1;
         4:       return 2;
         8:       return 3;
         20:      return 4;
         24:      return 5;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input int k, input int ch, input int sub, input logic [63:0] cnt);
      logic [31:0] v;
      v = 32'd0;
      case (k)
         1: v = (32'(m_div) << 8) | (32'(m_clr) << 2) | (32'(m_den) << 1) | 32'(m_ten);
         2: v = cnt[31:0];
         3: v = m_shadow;
         4: v = 32'(m_tier);
         5: for (int c = 0; c < NUM_CH; c++) v[c] = m_cstat[c];
         6: case (sub)
               0:       v = m_cmp[ch][31:0];
               1:       v = m_cmp[ch][63:32];
               2:       v = 32'(m_cctrl[ch]);
               default: v = 32'(m_cstat[ch]);
            endcase
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic model_edge(input logic rst, input logic w, input logic r,
                             input logic [11:0] a, input logic [31:0] d, input logic [63:0] cnt);
      int   k, ch, sub;
      logic mnow [NUM_CH];
      logic ev   [NUM_CH];
      logic any_pend;
      if (rst) begin
         m_ten = 1'b0; m_den = 1'b0; m_clr = 1'b0; m_div = 4'd1; m_tier = 1'b0;
         m_shadow = 32'd0; m_rdata = 32'd0; m_rvalid = 1'b0; m_err = 1'b0; m_irq = 1'b0;
         m_ldlo = 1'b0; m_ldhi = 1'b0; m_aclr = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_cmp[c] = MASK; m_cctrl[c] = 2'b00; m_cstat[c] = 1'b0; m_prev[c] = 1'b0;
         end
         return;
      end
      k = m_kind(a, ch, sub);
      any_pend = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         mnow[c]  = ((cnt & MASK) == m_cmp[c]);
         ev[c]    = mnow[c] && !m_prev[c];
         any_pend = any_pend | (m_cstat[c] & m_cctrl[c][0]);
      end
      m_irq  = m_tier & any_pend;
      m_aclr = ev[0] & m_cctrl[0][1];
      if (r) begin
         m_rdata = m_read(k, ch, sub, cnt);
         if (k == 2) m_shadow = cnt[63:32];
      end
      m_rvalid = r;
      m_err    = (w || r) && (k == 0);
      m_ldlo   = w && (k == 2);
      m_ldhi   = w && (k == 3);
      if (m_ldlo || m_ldhi) m_lddata = d;
      if (w) begin
         case (k)
            1: begin
               m_ten = d[0]; m_den = d[1]; m_clr = d[2];
               if (d[11:8] <= 4'd8) m_div = d[11:8];
            end
            4: m_tier = d[0];
            6: case (sub)
                  0:       m_cmp[ch] = {m_cmp[ch][63:32], d} & MASK;
                  1:       m_cmp[ch] = {d, m_cmp[ch][31:0]} & MASK;
                  2:       m_cctrl[ch] = d[1:0];
                  default: ;
               endcase
            default: ;
         endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (ev[c]) m_cstat[c] = 1'b1;
         else if (w && k == 6 && sub == 3 && ch == c && d[0]) m_cstat[c] = 1'b0;
         m_prev[c] = mnow[c];
      end
   endtask

   task automatic check_outputs();
      check_val("rdata", 64'(rdata), 64'(m_rdata));
      check_val("rvalid", 64'(rvalid), 64'(m_rvalid));
      check_val("err", 64'(err), 64'(m_err));
      check_val("irq", 64'(irq), 64'(m_irq));
      check_val("timer_en", 64'(timer_en), 64'(m_ten));
      check_val("div_en", 64'(div_en), 64'(m_den));
      check_val("count_clr", 64'(count_clr), 64'(m_clr | m_aclr));
      check_val("div_val", 64'(div_val), 64'(m_div));
      check_val("cnt_ld_lo", 64'(cnt_ld_lo), 64'(m_ldlo));
      check_val("cnt_ld_hi", 64'(cnt_ld_hi), 64'(m_ldhi));
      if (m_ldlo || m_ldhi) check_val("cnt_ld_data", 64'(cnt_ld_data), 64'(m_lddata));
      for (int c = 0; c < NUM_CH; c++)
         check_val("match", 64'(match[c]), 64'((64'(count) & MASK) == m_cmp[c]));
   endtask

   // Drive one cycle, advance the model at the edge, compare 1 time unit later
   task automatic step(input logic rst, input logic w, input logic r,
                       input logic [11:0] a, input logic [31:0] d);
      sys_rst = rst; w_en = w; r_en = r; addr = a; wdata = d; count = cur_cnt[CNT_W-1:0];
      @(posedge sys_clk);
      model_edge(rst, w, r, a, d, cur_cnt);
      #1;
      check_outputs();
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [11:0] a);
      step(1'b0, 1'b0, 1'b1, a, 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
   endtask

   logic [11:0] ra;
   logic [31:0] rdv;
   logic        rw, rr;

   initial begin
      cur_cnt = 64'd0;
      step(1'b1, 1'b0, 1'b0, 12'h000, 32'd0);
      step(1'b1, 1'b0, 1'b0, 12'h000, 32'd0);
      rd(12'h000);
      check_val("rst_tcr", 64'(rdata), 64'h0000_0100);

      // TCR load and illegal divisor retention
      wr(12'h000, 32'h0000_0503);
      check_val("tcr_div5", 64'(div_val), 64'd5);
      check_val("tcr_ten1", 64'(timer_en), 64'd1);
      check_val("tcr_den1", 64'(div_en), 64'd1);
      wr(12'h000, 32'h0000_0F00);
      check_val("tcr_div_keep", 64'(div_val), 64'd5);
      check_val("tcr_ten0", 64'(timer_en), 64'd0);

      // Coherent 64-bit counter read through the shadow
      cur_cnt = 64'h0001_2345_6789_ABCD;
      rd(12'h004);
      check_val("tdr0", 64'(rdata), 64'h6789_ABCD);
      cur_cnt = 64'h0009_8765_0000_0000;
      rd(12'h008);
      check_val("tdr1_shadow", 64'(rdata), 64'h0001_2345);

      // Channel 1 compare, status and interrupt
      cur_cnt = 64'd0;
      step(1'b1, 1'b0, 1'b0, 12'h000, 32'd0);
      wr(12'h030, 32'h10);
      wr(12'h034, 32'h0);
      wr(12'h038, 32'h1);
      wr(12'h014, 32'h1);
      cur_cnt = 64'h0F; idle();
      cur_cnt = 64'h10; idle();
      check_val("match1_rise", 64'(match[1]), 64'd1);
      check_val("irq_not_yet", 64'(irq), 64'd0);
      cur_cnt = 64'h11; idle();
      check_val("irq_high", 64'(irq), 64'd1);
      cur_cnt = 64'h12; rd(12'h018);
      check_val("tisr", 64'(rdata), 64'h2);

      // W1C colliding with a new match edge, then a quiet W1C
      cur_cnt = 64'h10; wr(12'h03C, 32'h1);
      rd(12'h03C);
      check_val("cstat_set_wins", 64'(rdata), 64'd1);
      cur_cnt = 64'h13; wr(12'h03C, 32'h1);
      idle();
      check_val("irq_low", 64'(irq), 64'd0);
      rd(12'h018);
      check_val("tisr_clear", 64'(rdata), 64'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         ra  = addr_tab[$urandom_range(0, 17)];
         rdv = $urandom;
         if (ra >= 12'h020 && ra[3:2] == 2'b00) rdv = 32'($urandom_range(0, 31));
         if (ra >= 12'h020 && ra[3:2] == 2'b01) rdv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: cur_cnt = cur_cnt + 64'd1;
            5, 6:          cur_cnt = 64'($urandom_range(0, 31));
            default:       cur_cnt = cur_cnt;
         endcase
         rw = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 1) == 0);
         step(1'b0, rw, rr, ra, rdv);
      end

      // Unmapped channel read, then reset during a read
      rd(12'h050);
      check_val("unmapped_rdata", 64'(rdata), 64'd0);
      check_val("unmapped_err", 64'(err), 64'd1);
      step(1'b1, 1'b0, 1'b1, 12'h000, 32'd0);
      check_val("rst_rvalid", 64'(rvalid), 64'd0);
      check_val("rst_irq", 64'(irq), 64'd0);
      for (int i = 0; i < 14; i++) rd(addr_tab[i]);
      rd(12'h000);
      check_val("rst_tcr2", 64'(rdata), 64'h0000_0100);
      rd(12'h020);
      check_val("rst_cmp0_lo", 64'(rdata), 64'hFFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_reg_bank.md
TIMER_REG_BANK -- requirements
Module: timer_reg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of compare channels (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 64, counter width (legal 33..64).
REQ-003 SHALL have ports: sys_clk in 1 clock; sys_rst in 1 reset, synchronous active-high (one clock; reset synchronous active-high).
REQ-004 SHALL have ports: w_en in 1 write strobe; r_en in 1 read strobe; addr in 12 byte address; wdata in 32 write data.
REQ-005 SHALL have ports: count in CNT_W live counter value; rdata out 32 read data; rvalid out 1 read data valid; err out 1 unmapped-access pulse.
REQ-006 SHALL have ports: timer_en, div_en, count_clr out 1 each; div_val out 4 divisor select.
REQ-007 SHALL have ports: cnt_ld_lo, cnt_ld_hi out 1 counter-load pulses; cnt_ld_data out 32 load value.
REQ-008 SHALL have ports: match out NUM_CH per-channel compare equality; irq out 1 combined interrupt.

Function
REQ-009 SHALL decode the register map: 0x00 TCR, 0x04 TDR0, 0x08 TDR1, 0x14 TIER, 0x18 TISR, and per channel c at 0x20+0x10*c: CMP_LO +0, CMP_HI +4, CCTRL +8, CSTAT +C.
REQ-010 SHALL, on a TCR write, load bit0 timer_en, bit1 div_en and bit2 count_clr, and load div_val from wdata[11:8] only if the value is 0..8; otherwise div_val SHALL be retained while bits 2:0 still update.
REQ-011 SHALL, on a TDR0/TDR1 write, pulse cnt_ld_lo/cnt_ld_hi for exactly one cycle with cnt_ld_data=wdata; this block does not hold the counter.
REQ-012 SHALL, on a TDR0 read, return count[31:0] and capture count[CNT_W-1:32] (zero-extended) into a shadow register in the same cycle; a TDR1 read SHALL return the shadow.
REQ-013 SHALL hold CMP_c = {CMP_HI, CMP_LO} truncated to CNT_W; each half SHALL be individually writable.
REQ-014 SHALL drive match[c] combinationally as (count == CMP_c).
REQ-015 SHALL set CSTAT[c] bit0 on the cycle after a rising edge of match[c] (match[c] & ~match_d[c]), not on a held match.
REQ-016 SHALL clear CSTAT[c] bit0 when it is written with wdata[0]=1 (W1C); writing 0 SHALL have no effect; a simultaneous set and clear SHALL leave the bit set.
REQ-017 SHALL use CCTRL[c] bit0 as per-channel int_en; when CCTRL bit1 (auto_clr) is set, a channel-0 match event SHALL pulse count_clr for one cycle in addition to the TCR bit.
REQ-018 SHALL treat TIER bit0 as global interrupt enable; TISR SHALL be read-only and return {CSTAT[NUM_CH-1:0]} in bits NUM_CH-1:0.
REQ-019 SHALL register irq = TIER[0] & |(CSTAT & CCTRL.int_en), one cycle after status changes.
REQ-020 SHALL register rdata and assert rvalid exactly one cycle after r_en; rdata SHALL hold its value until the next read.
REQ-021 SHALL return 0 and pulse err for one cycle on a read or write of an unmapped address or of a channel index >= NUM_CH; an unmapped write SHALL change no state.
REQ-022 SHALL give write priority over read when w_en and r_en are both high at the same address: the read returns the pre-write value.
REQ-023 SHALL read TCR as {20'b0, div_val, 5'b0, count_clr, div_en, timer_en}.

Reset
REQ-024 SHALL, on sys_rst high at a sys_clk edge, set TCR bits and TIER to 0, div_val to 1, every CMP_c to all-ones, CCTRL and CSTAT to 0, shadow to 0, match_d to 0.
REQ-025 SHALL hold rdata=0, rvalid=0, err=0, irq=0 and load pulses=0 during and after reset; reset SHALL abort any pending read.

Structure
REQ-026 SHALL take register offsets, channel stride, the div_val legal maximum (8) and reset constants from the shared timer package.
REQ-027 SHALL instantiate one sub-module, timer_cmp_ch, per channel via generate; it holds CMP, CCTRL and CSTAT, performs edge detection and W1C, and outputs match and status.

Verification
REQ-028 SHALL cover: write TCR 0x0000_0503 -> div_val=5, timer_en=1, div_en=1; then write 0x0000_0F00 -> div_val stays 5, timer_en=0.
REQ-029 SHALL cover: count=0x1_2345_6789_ABCD, read TDR0 -> 0x6789_ABCD; count changes, read TDR1 -> 0x0001_2345.
REQ-030 SHALL cover: CMP_1=0x10, CCTRL1=1, TIER=1, count sweeps 0x0F..0x12 -> CSTAT1 set once, irq high the next cycle, TISR=0x2.
REQ-031 SHALL cover: W1C of CSTAT1 in the same cycle as a new match edge -> CSTAT1 stays 1; W1C in a quiet cycle -> 0 and irq low one cycle later.
REQ-032 SHALL cover: read 0x50 with NUM_CH=2 -> rdata=0, err pulse; assert reset mid-read -> rvalid=0 and all registers at their reset values.
